// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// Module   : cache_pkg
// Purpose  : Shared types and geometry for the I/D cache memory arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

   localparam int ADDR_W      = 16;
   localparam int WORD_W      = 16;
   localparam int BLOCK_WORDS = 8;
   localparam int CNT_W       = $clog2(BLOCK_WORDS);
   localparam int BYTE_OFF_W  = 1;
   localparam int OFF_W       = CNT_W + BYTE_OFF_W;
   localparam int BASE_W      = ADDR_W - OFF_W;
   localparam int MEM_LAT     = 4;

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Word-aligned address of word idx within the block at base.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
      return {base, idx, {BYTE_OFF_W{1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
//------------------------------------------------------------------------------
// Module   : arb_pick
// Purpose  : I/D grant selection; fixed I-priority, or alternating on ties
//            when ARB_RR_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_pick
   import cache_pkg::*;
(
`ifdef ARB_RR_EN
   input  logic clk,
   input  logic rst,
   input  logic take,
`endif
   input  logic i_req,
   input  logic d_req,
   output logic grant_i,
   output logic grant_d
);

`ifdef ARB_RR_EN
   // High when data wins the next tie, i.e. instruction was granted last.
   logic r_prio_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio_d <= 1'b0;
      end else if (take && (grant_i || grant_d)) begin
         r_prio_d <= grant_i;
      end
   end

   assign grant_i = i_req && (!d_req || !r_prio_d);
   assign grant_d = d_req && (!i_req ||  r_prio_d);
`else
   assign grant_i = i_req;
   assign grant_d = d_req && !i_req;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Shares a 4-cycle pipelined memory between I-cache block fills and
//            D-cache fills/writes. Optional round-robin arbitration: ARB_RR_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_wr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_valid,
   output logic              fill_we_i,
   output logic              fill_we_d,
   output logic [CNT_W-1:0]  fill_word,
   output logic              tag_we_i,
   output logic              tag_we_d,
   output logic              i_busy,
   output logic              d_busy,
   output logic              i_done,
   output logic              d_done
);

   state_t              r_state;
   state_t              w_next;
   logic                r_side_d;
   logic [ADDR_W-1:0]   r_addr;
   logic [WORD_W-1:0]   r_wdata;
   logic [CNT_W-1:0]    r_issue_cnt;
   logic [CNT_W-1:0]    r_recv_cnt;
   logic                r_issue_done;
   logic [MEM_LAT-1:0]  r_pend;

   logic                w_grant_i;
   logic                w_grant_d;
   logic                w_grant;
   logic                w_take;
   logic                w_rd_issue;
   logic                w_beat;
   logic                w_last_beat;
   logic [BASE_W-1:0]   w_base;

   arb_pick u_arb_pick (
`ifdef ARB_RR_EN
      .clk     (clk),
      .rst     (rst),
      .take    (w_take),
`endif
      .i_req   (i_req),
      .d_req   (d_req),
      .grant_i (w_grant_i),
      .grant_d (w_grant_d)
   );

   assign w_take      = (r_state == ST_IDLE);
   assign w_grant     = w_take && (w_grant_i || w_grant_d);
   assign w_base      = r_addr[ADDR_W-1:OFF_W];
   assign w_rd_issue  = (r_state == ST_FILL) && !r_issue_done;
   // r_pend tracks our own reads through the memory pipe, so responses to
   // reads issued before a reset never count as fill beats.
   assign w_beat      = (r_state == ST_FILL) && mem_valid && r_pend[MEM_LAT-1];
   assign w_last_beat = w_beat && (r_recv_cnt == LAST_WORD);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_side_d     <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_issue_cnt  <= '0;
         r_recv_cnt   <= '0;
         r_issue_done <= 1'b0;
         r_pend       <= '0;
      end else begin
         r_state <= w_next;
         r_pend  <= {r_pend[MEM_LAT-2:0], w_rd_issue};
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_side_d     <= w_grant_d;
                  r_addr       <= w_grant_d ? d_addr : i_addr;
                  r_wdata      <= d_wdata;
                  r_issue_cnt  <= '0;
                  r_recv_cnt   <= '0;
                  r_issue_done <= 1'b0;
               end
            end
            ST_FILL: begin
               if (!r_issue_done) begin
                  if (r_issue_cnt == LAST_WORD) begin
                     r_issue_done <= 1'b1;
                  end else begin
                     r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                  end
               end
               if (w_beat) begin
                  r_recv_cnt <= r_recv_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_d && d_wr) begin
               w_next = ST_WRITE;
            end else if (w_grant) begin
               w_next = ST_FILL;
            end
         end
         ST_FILL:  if (w_last_beat) w_next = ST_DONE;
         ST_WRITE: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Outputs are forced low while rst is high, even mid-operation.
   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_we_i = 1'b0;
      fill_we_d = 1'b0;
      fill_word = '0;
      tag_we_i  = 1'b0;
      tag_we_d  = 1'b0;
      i_busy    = 1'b0;
      d_busy    = 1'b0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_FILL: begin
               i_busy = !r_side_d;
               d_busy =  r_side_d;
               if (!r_issue_done) begin
                  mem_en   = 1'b1;
                  mem_addr = word_addr(w_base, r_issue_cnt);
               end
               if (w_beat) begin
                  fill_we_i = !r_side_d;
                  fill_we_d =  r_side_d;
                  fill_word = r_recv_cnt;
               end
               if (w_last_beat) begin
                  tag_we_i = !r_side_d;
                  tag_we_d =  r_side_d;
               end
            end
            ST_WRITE: begin
               d_busy    = 1'b1;
               mem_en    = 1'b1;
               mem_wr    = 1'b1;
               mem_addr  = r_addr;
               mem_wdata = r_wdata;
            end
            ST_DONE: begin
               i_busy = !r_side_d;
               d_busy =  r_side_d;
               i_done = !r_side_d;
               d_done =  r_side_d;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter with a 4-cycle memory model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        mem_en, mem_wr, mem_valid;
   logic [15:0] mem_addr, mem_wdata;
   logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d;
   logic [2:0]  fill_word;
   logic        i_busy, d_busy, i_done, d_done;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_valid(mem_valid),
      .fill_we_i(fill_we_i), .fill_we_d(fill_we_d), .fill_word(fill_word),
      .tag_we_i(tag_we_i), .tag_we_d(tag_we_d),
      .i_busy(i_busy), .d_busy(d_busy), .i_done(i_done), .d_done(d_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read data valid 4 cycles after each accepted read; not reset.
   logic [3:0] mem_pipe = 4'b0;
   always @(posedge clk) mem_pipe <= {mem_pipe[2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
   assign mem_valid = mem_pipe[3];

   typedef struct {
      int         cyc;
      logic [3:0] kind;
      logic [39:0] pay;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk = 0;
   int  n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input logic [3:0] k, input logic [39:0] p);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.pay  = p;
      exp_q.push_back(e);
   endtask

   // Expected events of one operation granted at the end of cycle c0.
   // n_rd limits the reads (used when the fill is cut short by reset).
   task automatic push_op(input logic side_d, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int c0, input int n_rd);
      logic [15:0] base;
      if (wr) begin
         push_ev(c0 + 1, 4'd0, {7'b0, 1'b1, addr, wdata});
         push_ev(c0 + 2, 4'd3, {36'b0, 4'b0101});
      end else begin
         base = addr & 16'hFFF0;
         for (int t = 1; t <= 13; t++) begin
            if (t <= n_rd)
               push_ev(c0 + t, 4'd0, {7'b0, 1'b0, base + 16'(2 * (t - 1)), 16'h0});
            if (n_rd == 8 && t >= 5 && t <= 12)
               push_ev(c0 + t, 4'd1, {35'b0, !side_d, side_d, 3'(t - 5)});
            if (n_rd == 8 && t == 12)
               push_ev(c0 + t, 4'd2, {38'b0, !side_d, side_d});
            if (n_rd == 8 && t == 13)
               push_ev(c0 + t, 4'd3, {36'b0, !side_d, side_d, !side_d, side_d});
         end
      end
   endtask

   task automatic take_ev(input logic [3:0] k, input logic [39:0] p, input string nm);
      ev_t e;
      if (exp_q.size() == 0) begin
         check({nm, "_unexpected"}, {20'h1, k, p}, 64'h0);
      end else begin
         e = exp_q.pop_front();
         check({nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
         check({nm, "_value"}, {20'h0, k, p}, {20'h0, e.kind, e.pay});
      end
   endtask

   always @(negedge clk) begin
      if (mem_en)
         take_ev(4'd0, {7'b0, mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0}, "mem");
      if (fill_we_i || fill_we_d)
         take_ev(4'd1, {35'b0, fill_we_i, fill_we_d, fill_word}, "fill");
      if (tag_we_i || tag_we_d)
         take_ev(4'd2, {38'b0, tag_we_i, tag_we_d}, "tag");
      if (i_done || d_done)
         take_ev(4'd3, {36'b0, i_done, d_done, i_busy, d_busy}, "done");
   end

   function automatic logic [63:0] all_outs();
      return {19'b0, mem_en, mem_wr, mem_addr, mem_wdata, fill_we_i, fill_we_d, fill_word,
              tag_we_i, tag_we_d, i_busy, d_busy, i_done, d_done};
   endfunction

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   int c0, c1;

   initial begin
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", all_outs(), 64'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_outputs", all_outs(), 64'h0);

      // Instruction fill of 0x1236
      @(posedge clk); #1;
      c0 = cyc;
      i_req = 1'b1; i_addr = 16'h1236;
      push_op(1'b0, 1'b0, 16'h1236, 16'h0, c0, 8);
      wait_until(c0 + 13);
      i_req = 1'b0;
      wait_until(c0 + 16);

      // Data write
      c0 = cyc;
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00A2; d_wdata = 16'hBEEF;
      push_op(1'b1, 1'b1, 16'h00A2, 16'hBEEF, c0, 8);
      wait_until(c0 + 2);
      d_req = 1'b0; d_wr = 1'b0;
      wait_until(c0 + 5);

      // Simultaneous requests: instruction first, then data fill of 0x4000
      c0 = cyc;
      i_req = 1'b1; i_addr = 16'h3018;
      d_req = 1'b1; d_addr = 16'h4000; d_wr = 1'b0;
      push_op(1'b0, 1'b0, 16'h3018, 16'h0, c0, 8);
      push_op(1'b1, 1'b0, 16'h4000, 16'h0, c0 + 14, 8);
      wait_until(c0 + 13);
      i_req = 1'b0;
      wait_until(c0 + 27);
      d_req = 1'b0;
      wait_until(c0 + 30);

`ifdef ARB_RR_EN
      // Both sides held: grants alternate I, D, I, D
      c0 = cyc;
      i_req = 1'b1; i_addr = 16'h7770;
      d_req = 1'b1; d_addr = 16'h8884;
      push_op(1'b0, 1'b0, 16'h7770, 16'h0, c0, 8);
      push_op(1'b1, 1'b0, 16'h8884, 16'h0, c0 + 14, 8);
      push_op(1'b0, 1'b0, 16'h7770, 16'h0, c0 + 28, 8);
      push_op(1'b1, 1'b0, 16'h8884, 16'h0, c0 + 42, 8);
      wait_until(c0 + 55);
      i_req = 1'b0; d_req = 1'b0;
      wait_until(c0 + 58);
`endif

      // Reset on the 5th fill cycle, then a clean fill with stale responses in flight
      c0 = cyc;
      i_req = 1'b1; i_addr = 16'h5550;
      push_op(1'b0, 1'b0, 16'h5550, 16'h0, c0, 4);
      wait_until(c0 + 5);
      rst = 1'b1; i_req = 1'b0;
      @(negedge clk);
      check("rst_mid_fill_outputs", all_outs(), 64'h0);
      wait_until(c0 + 6);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_outputs", all_outs(), 64'h0);
      wait_until(c0 + 7);
      c1 = cyc;
      i_req = 1'b1; i_addr = 16'h666A;
      push_op(1'b0, 1'b0, 16'h666A, 16'h0, c1, 8);
      wait_until(c1 + 3);
      i_req = 1'b0;
      wait_until(c1 + 17);

      check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports clk input 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst input 1, reset; synchronous, active-high.
REQ-003 SHALL have ports i_req input 1 and i_addr input 16: I-cache fill request and miss address, held until i_done.
REQ-004 SHALL have ports d_req input 1, d_addr input 16, d_wr input 1 and d_wdata input 16: D-cache request, address, write flag and write data, held until d_done.
REQ-005 SHALL have ports mem_en output 1, mem_wr output 1, mem_addr output 16 and mem_wdata output 16 driving the shared 4-cycle pipelined memory.
REQ-006 SHALL have port mem_valid input 1: memory read data valid, exactly 4 cycles after each accepted read.
REQ-007 SHALL have ports fill_we_i output 1, fill_we_d output 1 and fill_word output 3: per-word data-array write enables and word select.
REQ-008 SHALL have ports tag_we_i output 1 and tag_we_d output 1: metadata write strobes.
REQ-009 SHALL have ports i_busy, d_busy, i_done and d_done, each output 1: busy (level) and completion (1-cycle pulse) per requester.

Function
REQ-010 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-011 IDLE SHALL sample requests; a grant SHALL take effect on the next edge, so the first mem_en occurs 1 cycle after a request is seen.
REQ-012 Arbitration SHALL use fixed priority: instruction over data, unless ARB_RR_EN is defined.
REQ-013 A granted read SHALL latch base = addr[15:4] and enter FILL.
REQ-014 FILL SHALL issue 8 reads on consecutive cycles: mem_en=1, mem_wr=0, mem_addr={base,issue_cnt,1'b0}, with issue_cnt counting 0..7.
REQ-015 FILL SHALL stop issuing after issue_cnt=7, while recv_cnt continues counting mem_valid beats.
REQ-016 Each mem_valid in FILL SHALL assert fill_we_x for the granted side only, with fill_word=recv_cnt.
REQ-017 The beat with recv_cnt=7 SHALL pulse tag_we_x and move to DONE.
REQ-018 Fill latency from grant to tag_we SHALL be 12 cycles.
REQ-019 A granted data write SHALL enter WRITE for 1 cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata; no tag_we or fill_we is asserted.
REQ-020 DONE SHALL pulse x_done for 1 cycle and return to IDLE; the next grant is no earlier than the cycle after DONE.
REQ-021 x_busy SHALL be high from grant through DONE inclusive.
REQ-022 mem_valid in IDLE, WRITE or DONE SHALL be ignored.
REQ-023 A request dropped mid-operation SHALL NOT abort the operation.
REQ-024 Counters SHALL be 3 bits; recv_cnt wrapping from 7 to 0 occurs only on the exit beat.

Reset
REQ-025 rst SHALL force IDLE, clear issue_cnt, recv_cnt and base, and set the round-robin pointer to favour instruction.
REQ-026 Every output SHALL be 0 during and after reset until the next grant, including when rst is asserted mid-FILL.
REQ-027 Memory responses still in flight at reset SHALL be ignored.

Configuration
REQ-028 With ARB_RR_EN defined, simultaneous requests SHALL alternate, the side not granted last winning; single requests are granted immediately.
REQ-029 Without ARB_RR_EN, instruction SHALL always win ties, and no pointer flop is built.

Structure
REQ-030 cache_pkg SHALL hold the state enum, BLOCK_WORDS=8, ADDR_W=16, WORD_W=16 and the offset-field constants.
REQ-031 One sub-module, arb_pick, SHALL contain the grant logic and the optional round-robin pointer.

Verification
REQ-032 i_req with i_addr=0x1236: mem_addr SHALL be 0x1230..0x123E over 8 cycles, fill_word 0..7, tag_we_i at grant+12, then i_done.
REQ-033 i_req and d_req (read, 0x4000) in the same cycle, macro off: instruction fill completes first, then d fill of 0x4000..0x400E.
REQ-034 With ARB_RR_EN and both sides requesting continuously: grants SHALL alternate I, D, I, D.
REQ-035 d_req, d_wr=1, d_addr=0x00A2, d_wdata=0xBEEF: SHALL produce one cycle of mem_en=1 and mem_wr=1 with that address and data, then d_done, with no tag_we.
REQ-036 rst asserted on the 5th FILL cycle: all outputs SHALL be 0 next cycle, late mem_valid SHALL be ignored, and a new i_req SHALL perform a clean 8-beat fill.
